// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: shared FSM state type and default widths for pattern_scan_ctrl
package pattern_scan_pkg;
  typedef enum logic [1:0] {IDLE, WAIT, SHIFT, DONE} state_t;
  localparam int WORD_W_DEF = 8;
  localparam int PAT_W_DEF = 5;
  localparam int CNT_W_DEF = 8;
endpackage

// File: rtl/pattern_scan_ctrl_matcher.sv
// pattern_matcher: serial bit-history compare against a PAT_W-bit pattern, registered match pulse
//  clk, rst  clock, async active-high reset
//  clr       clears history, fill count and pulse (frame start)
//  bit_in    serial bit, sampled when bit_en is high
//  pattern   pattern; MSB is compared against the oldest bit
//  match     one-cycle pulse the cycle after the completing bit
//  Build option NONOVERLAP_EN: history fill restarts after every match.
module pattern_matcher #(
  parameter int PAT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             bit_in,
  input  logic             bit_en,
  input  logic [PAT_W-1:0] pattern,
  output logic             match
);
  localparam int FW = $clog2(PAT_W + 1);
  logic [PAT_W-1:0] hist, hist_n;
  logic [FW-1:0] fill, fill_n;
  logic hit;
  always_comb begin
    hist_n = {hist[PAT_W-2:0], bit_in};
    fill_n = (fill == FW'(PAT_W)) ? fill : fill + 1'b1;
    hit = bit_en && fill_n == FW'(PAT_W) && hist_n == pattern;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
    end else if (clr) begin
      hist <= '0;
      fill <= '0;
      match <= 1'b0;
    end else begin
      match <= hit;
      if (bit_en) begin
        hist <= hist_n;
`ifdef NONOVERLAP_EN
        fill <= hit ? '0 : fill_n;
`else
        fill <= fill_n;
`endif
      end
    end
  end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: framed word serialiser driving a programmable serial pattern detector
//  clk, rst           clock, async active-high reset
//  start, pattern     frame start (IDLE only) and pattern latched with it
//  in_valid/in_ready  word handshake; in_ready high only in WAIT
//  in_word, in_last   data word and end-of-frame flag
//  bit_out, bit_valid serial bit (MSB first) presented in SHIFT
//  match_pulse        registered pulse per match
//  match_cnt          saturating match count, held until the next start
//  busy, done         not-IDLE flag; one-cycle end-of-frame pulse
//  Build option NONOVERLAP_EN (in pattern_matcher): non-overlapping detection.
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF,
  parameter int PAT_W = PAT_W_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [PAT_W-1:0]  pattern,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_word,
  input  logic              in_last,
  output logic              bit_out,
  output logic              bit_valid,
  output logic              match_pulse,
  output logic [CNT_W-1:0]  match_cnt,
  output logic              busy,
  output logic              done
);
  localparam int BC_W = $clog2(WORD_W);
  state_t state, state_n;
  logic [WORD_W-1:0] word_q;
  logic last_q;
  logic [BC_W-1:0] bitcnt;
  logic [PAT_W-1:0] pat_q;
  logic frame_start;
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:  state_n = start ? WAIT : IDLE;
      WAIT:  state_n = in_valid ? SHIFT : WAIT;
      SHIFT: state_n = (bitcnt == '0) ? (last_q ? DONE : WAIT) : SHIFT;
      DONE:  state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  assign frame_start = state == IDLE && start;
  assign in_ready = state == WAIT;
  assign bit_valid = state == SHIFT;
  assign bit_out = bit_valid & word_q[bitcnt];
  assign busy = state != IDLE;
  assign done = state == DONE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      word_q <= '0;
      last_q <= 1'b0;
      bitcnt <= '0;
      pat_q <= '0;
      match_cnt <= '0;
    end else begin
      state <= state_n;
      if (frame_start) begin
        pat_q <= pattern;
        match_cnt <= '0;
      end else if (match_pulse && match_cnt != '1) begin
        match_cnt <= match_cnt + 1'b1;
      end
      if (state == WAIT && in_valid) begin
        word_q <= in_word;
        last_q <= in_last;
        bitcnt <= BC_W'(WORD_W - 1);
      end else if (state == SHIFT) begin
        bitcnt <= bitcnt - 1'b1;
      end
    end
  end
  pattern_matcher #(.PAT_W(PAT_W)) u_matcher (
    .clk     (clk),
    .rst     (rst),
    .clr     (frame_start),
    .bit_in  (bit_out),
    .bit_en  (bit_valid),
    .pattern (pat_q),
    .match   (match_pulse)
  );
endmodule
